binary_to_excess3: RTL and testbench
====================================

Name: binary_to_excess3

Overview:
- Registered code converter: each 4-bit input nibble B is mapped to its excess-3 code E = B + 3, modulo 16.
- Sits in the datapath between BCD/binary digit sources and excess-3 consumers, such as self-complementing adders and display logic.
- Parameterised for several packed nibbles converted in parallel.
- Also flags nibbles that are not valid BCD digits.

Parameters:
- NDIGITS, 1, number of packed 4-bit nibbles converted in parallel (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  B is valid this cycle.
- B  input  4*NDIGITS  packed input nibbles; nibble i is B[4i+3:4i].
- out_valid  output  1  E/bcd_err/wrap are valid.
- E  output  4*NDIGITS  packed excess-3 result; nibble i is E[4i+3:4i].
- bcd_err  output  NDIGITS  bit i set when input nibble i > 9 (not a BCD digit).
- wrap  output  NDIGITS  bit i set when input nibble i >= 13, i.e. B+3 overflowed 4 bits.

Behaviour:
- Reset, asynchronous with rst=1:
  - out_valid=0, E=0, bcd_err=0, wrap=0 immediately, held while rst=1.
  - First capture is on the first rising clk edge after rst deasserts.
- Per nibble i, computed combinationally from B and registered:
  - E_i = (B_i + 4'd3) mod 16, a 4-bit add with carry discarded.
  - Full mapping: 0->3, 1->4, 2->5, 3->6, 4->7, 5->8, 6->9, 7->10, 8->11, 9->12, 10->13, 11->14, 12->15, 13->0, 14->1, 15->2.
  - bcd_err_i = (B_i > 9).
  - wrap_i = carry out of B_i+3, i.e. (B_i >= 13).
  - Non-BCD inputs (10..15) are still converted by the modulo rule above; conversion is never suppressed, only flagged.
- Latency: exactly 1 clock.
  - When in_valid=1 at a rising edge, E/bcd_err/wrap load the results for that B and out_valid=1 on the following cycle.
- When in_valid=0 at a rising edge:
  - out_valid goes 0.
  - E, bcd_err and wrap hold their previous values (no update).
- Throughput: one new input per clock; back-to-back in_valid=1 yields back-to-back results with no bubbles.
- Nibbles are independent: no carry propagates between digits.
- Reset asserted mid-stream: outputs clear immediately; any in-flight result is discarded.
- No other state; no handshake back-pressure (no ready signal).

Test Plan:
- Reset check: assert rst for 3 cycles with in_valid=1, B=4'h5 -> out_valid=0, E=0, bcd_err=0, wrap=0 throughout; release rst -> next cycle E=4'h8, out_valid=1.
- Exhaustive sweep, NDIGITS=1: apply B=0..15 on consecutive cycles with in_valid=1 -> one cycle later E follows 3,4,...,15,0,1,2. bcd_err=1 only for B=10..15; wrap=1 only for B=13..15.
- Hold behaviour: B=4'h2 with in_valid=1, then B=4'h9 with in_valid=0 -> E stays 4'h5 and out_valid drops to 0.
- Multi-digit, NDIGITS=2: B=8'h97 -> E=8'hCA, bcd_err=2'b00, wrap=2'b00. B=8'hD4 -> E=8'h07, bcd_err=2'b10, wrap=2'b10.
- Mid-stream reset: stream B=1,2,3 with in_valid=1 and pulse rst asynchronously between clock edges after B=2 -> outputs clear at once. The first result after release comes from the first sampled input and appears one cycle later.
- Boundary pair: B=4'h9 -> E=4'hC, bcd_err=0. B=4'hA -> E=4'hD, bcd_err=1, wrap=0.

Source files
------------

// File: rtl/binary_to_excess3_if.sv
// Bus bundle for the excess-3 converter: input nibbles in,
// registered excess-3 codes and per-digit flags out.
interface binary_to_excess3_if #(
    parameter int NDIGITS = 1
);
    logic                   in_valid;
    logic [4*NDIGITS-1:0]   B;
    logic                   out_valid;
    logic [4*NDIGITS-1:0]   E;
    logic [NDIGITS-1:0]     bcd_err;
    logic [NDIGITS-1:0]     wrap;

    modport master (
        output in_valid, B,
        input  out_valid, E, bcd_err, wrap
    );

    modport slave (
        input  in_valid, B,
        output out_valid, E, bcd_err, wrap
    );
endinterface

// File: rtl/binary_to_excess3.sv
// Registered binary-to-excess-3 converter, NDIGITS nibbles in parallel,
// flagging non-BCD nibbles and nibbles whose +3 wraps past 15.
module binary_to_excess3 #(
    parameter int NDIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    binary_to_excess3_if.slave    bus
);
    logic [4*NDIGITS-1:0] w_e;
    logic [NDIGITS-1:0]   w_err;
    logic [NDIGITS-1:0]   w_wrap;

    logic                 r_valid;
    logic [4*NDIGITS-1:0] r_e;
    logic [NDIGITS-1:0]   r_err;
    logic [NDIGITS-1:0]   r_wrap;

    // Each nibble is independent; the 5th sum bit is the wrap flag.
    always_comb begin
        w_e    = '0;
        w_err  = '0;
        w_wrap = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            logic [4:0] w_sum;
            w_sum            = {1'b0, bus.B[4*i +: 4]} + 5'd3;
            w_e[4*i +: 4]    = w_sum[3:0];
            w_wrap[i]        = w_sum[4];
            w_err[i]         = (bus.B[4*i +: 4] > 4'd9);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_e     <= '0;
            r_err   <= '0;
            r_wrap  <= '0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_e    <= w_e;
                r_err  <= w_err;
                r_wrap <= w_wrap;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.E         = r_e;
    assign bus.bcd_err   = r_err;
    assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_binary_to_excess3.sv
// Directed bench for binary_to_excess3 with one- and two-digit
// instances sharing clock and reset.
module tb_binary_to_excess3;
    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    binary_to_excess3_if #(.NDIGITS(1)) bus1 ();
    binary_to_excess3_if #(.NDIGITS(2)) bus2 ();

    binary_to_excess3 #(.NDIGITS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    binary_to_excess3 #(.NDIGITS(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic v,
                        input logic [3:0] e, input logic err,
                        input logic wr);
        chk({tag, ".valid"}, {31'd0, bus1.out_valid}, {31'd0, v});
        chk({tag, ".E"}, {28'd0, bus1.E}, {28'd0, e});
        chk({tag, ".err"}, {31'd0, bus1.bcd_err}, {31'd0, err});
        chk({tag, ".wrap"}, {31'd0, bus1.wrap}, {31'd0, wr});
    endtask

    // Hand-written excess-3 table for B = 0..15.
    logic [3:0] e_tab [16] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                               4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE,
                               4'hF, 4'h0, 4'h1, 4'h2};
    logic       err_tab [16] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1};
    logic       wr_tab [16]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.B = 4'h5;
        bus2.in_valid = 1'b0;
        bus2.B = 8'h00;

        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("reset", 1'b0, 4'h0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk1("rel", 1'b1, 4'h8, 1'b0, 1'b0);

        for (int b = 0; b < 16; b++) begin
            bus1.B = 4'(b);
            tick();
            chk1($sformatf("sweep%0d", b), 1'b1, e_tab[b],
                 err_tab[b], wr_tab[b]);
        end

        bus1.B = 4'h2;
        tick();
        chk1("hold_a", 1'b1, 4'h5, 1'b0, 1'b0);
        bus1.in_valid = 1'b0;
        bus1.B = 4'h9;
        tick();
        chk1("hold_b", 1'b0, 4'h5, 1'b0, 1'b0);
        tick();
        chk1("hold_c", 1'b0, 4'h5, 1'b0, 1'b0);

        bus2.in_valid = 1'b1;
        bus2.B = 8'h97;
        tick();
        chk("d2_97.valid", {31'd0, bus2.out_valid}, 32'd1);
        chk("d2_97.E", {24'd0, bus2.E}, 32'h0000_00CA);
        chk("d2_97.err", {30'd0, bus2.bcd_err}, 32'd0);
        chk("d2_97.wrap", {30'd0, bus2.wrap}, 32'd0);
        bus2.B = 8'hD4;
        tick();
        chk("d2_D4.E", {24'd0, bus2.E}, 32'h0000_0007);
        chk("d2_D4.err", {30'd0, bus2.bcd_err}, 32'd2);
        chk("d2_D4.wrap", {30'd0, bus2.wrap}, 32'd2);
        bus2.in_valid = 1'b0;

        bus1.in_valid = 1'b1;
        bus1.B = 4'h1;
        tick();
        chk1("ms1", 1'b1, 4'h4, 1'b0, 1'b0);
        bus1.B = 4'h2;
        tick();
        chk1("ms2", 1'b1, 4'h5, 1'b0, 1'b0);
        bus1.B = 4'h3;
        #2;
        rst = 1'b1;
        #1;
        chk1("ms_rst", 1'b0, 4'h0, 1'b0, 1'b0);
        chk("ms_rst.d2E", {24'd0, bus2.E}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk1("ms_rel", 1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        chk1("ms3", 1'b1, 4'h6, 1'b0, 1'b0);

        bus1.B = 4'h9;
        tick();
        chk1("bnd9", 1'b1, 4'hC, 1'b0, 1'b0);
        bus1.B = 4'hA;
        tick();
        chk1("bndA", 1'b1, 4'hD, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
